// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             z;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             B;

    modport master (output start, x, y, z, input busy, done, D, B);
    modport slave  (input start, x, y, z, output busy, done, D, B);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell iterated LSB-first,
// producing D = x - y - z mod 2^WIDTH and the final borrow B.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] min_q, min_n;
    logic [WIDTH-1:0] sub_q, sub_n;
    logic [WIDTH-1:0] diff_q, diff_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             br_q, br_n;
    logic             bout_q, bout_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             d_bit, bo_bit;

    // The single full-subtractor cell on the operand LSBs
    assign d_bit  = min_q[0] ^ sub_q[0] ^ br_q;
    assign bo_bit = (~min_q[0] & sub_q[0]) | (~(min_q[0] ^ sub_q[0]) & br_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            min_q   <= '0;
            sub_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            min_q   <= min_n;
            sub_q   <= sub_n;
            diff_q  <= diff_n;
            cnt_q   <= cnt_n;
            br_q    <= br_n;
            bout_q  <= bout_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        min_n   = min_q;
        sub_n   = sub_q;
        diff_n  = diff_q;
        cnt_n   = cnt_q;
        br_n    = br_q;
        bout_n  = bout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    min_n   = bus.x;
                    sub_n   = bus.y;
                    br_n    = bus.z;
                    cnt_n   = '0;
                    diff_n  = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so bit 0 ends up at position 0
                diff_n = (diff_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
                min_n  = min_q >> 1;
                sub_n  = sub_q >> 1;
                br_n   = bo_bit;
                cnt_n  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bout_n  = bo_bit;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == SHIFT);
        done_n = (state_n == DONE);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.D    = diff_q;
    assign bus.B    = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 builds)
// against an arithmetic reference model.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Observation mux so one task can drive and check either build
    logic        sel;
    logic        obs_busy, obs_done, obs_b;
    logic [31:0] obs_d;
    always_comb begin
        obs_busy = sel ? bus1.busy : bus8.busy;
        obs_done = sel ? bus1.done : bus8.done;
        obs_b    = sel ? bus1.B    : bus8.B;
        obs_d    = sel ? 32'(bus1.D) : 32'(bus8.D);
    end

    logic [31:0] last_d [2];
    logic        last_b [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    task automatic ref_model(input int w, input logic [31:0] xv, input logic [31:0] yv,
                             input logic zv, output logic [31:0] d, output logic b);
        longint full;
        longint mask;
        mask = (64'sd1 <<< w) - 1;
        full = longint'(xv & 32'(mask)) - longint'(yv & 32'(mask)) - longint'(zv);
        d = 32'(full & mask);
        b = (full < 0);
    endtask

    task automatic drive(input bit w1, input logic s, input logic [31:0] xv,
                         input logic [31:0] yv, input logic zv);
        if (w1) begin
            bus1.start = s; bus1.x = 1'(xv); bus1.y = 1'(yv); bus1.z = zv;
        end else begin
            bus8.start = s; bus8.x = 8'(xv); bus8.y = 8'(yv); bus8.z = zv;
        end
    endtask

    task automatic run_op(input bit w1, input logic [31:0] xv, input logic [31:0] yv,
                          input logic zv, input bit mid_start, input int rst_at);
        logic [31:0] exp_d;
        logic        exp_b;
        int          w;
        w   = w1 ? 1 : 8;
        sel = w1;
        ref_model(w, xv, yv, zv, exp_d, exp_b);
        @(negedge clk);
        drive(w1, 1'b1, xv, yv, zv);
        @(posedge clk);
        #1;
        drive(w1, 1'b0, $urandom, $urandom, 1'($urandom));
        check("d_clear_on_accept", obs_d, 32'd0);
        check("b_hold_on_accept", 32'(obs_b), 32'(last_b[w1]));
        for (int i = 0; i < w; i++) begin
            check("busy_in_shift", 32'(obs_busy), 32'd1);
            check("no_done_in_shift", 32'(obs_done), 32'd0);
            if (i == rst_at) begin
                rst = 1'b1;
                drive(w1, 1'b0, 32'd0, 32'd0, 1'b0);
                #1;
                check("rst_busy", 32'(obs_busy), 32'd0);
                check("rst_done", 32'(obs_done), 32'd0);
                check("rst_d", obs_d, 32'd0);
                check("rst_b", 32'(obs_b), 32'd0);
                repeat (2) begin
                    @(posedge clk);
                    #1;
                    check("rst_no_done", 32'(obs_done), 32'd0);
                end
                rst = 1'b0;
                last_b[0] = 1'b0; last_b[1] = 1'b0;
                last_d[0] = '0;   last_d[1] = '0;
                return;
            end
            // A start request mid-operation must be ignored
            if (mid_start && i == 2) drive(w1, 1'b1, 32'h0, 32'h1, 1'b0);
            else                     drive(w1, 1'b0, $urandom, $urandom, 1'($urandom));
            @(posedge clk);
            #1;
        end
        drive(w1, 1'b0, $urandom, $urandom, 1'($urandom));
        check("done_pulse", 32'(obs_done), 32'd1);
        check("busy_low_at_done", 32'(obs_busy), 32'd0);
        check("result_d", obs_d, exp_d);
        check("result_b", 32'(obs_b), 32'(exp_b));
        last_d[w1] = exp_d;
        last_b[w1] = exp_b;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(obs_done), 32'd0);
        check("busy_idle", 32'(obs_busy), 32'd0);
        check("d_hold_idle", obs_d, exp_d);
        check("b_hold_idle", 32'(obs_b), 32'(exp_b));
    endtask

    initial begin
        sel = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        last_b[0] = 1'b0; last_b[1] = 1'b0;
        last_d[0] = '0;   last_d[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check("reset_busy", 32'(obs_busy), 32'd0);
            check("reset_done", 32'(obs_done), 32'd0);
            check("reset_d", obs_d, 32'd0);
            check("reset_b", 32'(obs_b), 32'd0);
        end
        rst = 1'b0;

        // Directed WIDTH=8 cases
        run_op(1'b0, 32'h05, 32'h03, 1'b0, 1'b0, -1);
        run_op(1'b0, 32'h03, 32'h05, 1'b0, 1'b0, -1);
        run_op(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, -1);
        run_op(1'b0, 32'hFF, 32'hFF, 1'b0, 1'b0, -1);
        run_op(1'b0, 32'h05, 32'h03, 1'b0, 1'b1, -1);
        run_op(1'b0, 32'h05, 32'h03, 1'b0, 1'b0, 3);
        run_op(1'b0, 32'h80, 32'h01, 1'b0, 1'b0, -1);

        // WIDTH=1: full-subtractor truth table
        for (int c = 0; c < 8; c++) begin
            logic [2:0] cv;
            cv = 3'(c);
            run_op(1'b1, 32'(cv[2]), 32'(cv[1]), cv[0], 1'b0, -1);
        end

        // Randomized operations with idle gaps of changing inputs
        for (int n = 0; n < 30; n++) begin
            bit w1;
            w1 = ($urandom_range(0, 3) == 0);
            run_op(w1, $urandom, $urandom, 1'($urandom), 1'($urandom), -1);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                drive(w1, 1'b0, $urandom, $urandom, 1'($urandom));
                @(posedge clk);
                #1;
                sel = w1;
                #1;
                check("idle_d_hold", obs_d, last_d[w1]);
                check("idle_b_hold", 32'(obs_b), 32'(last_b[w1]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
